// File: rtl/fx_div_seq_if.sv
// ---------------------------------------------------------------------------
// fx_div_seq_if
// Handshake bundle for the iterative fixed-point divider.
//
// Request side  : in_valid, in_ready, numerator, denominator, in_tag
// Response side : out_valid, out_ready, result, out_tag, dz, ovf
// Status        : busy
//
// The master modport is the side that issues divides and consumes results.
// The slave modport is the divider itself.
// ---------------------------------------------------------------------------
interface fx_div_seq_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] numerator;
  logic [WIDTH-1:0] denominator;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [TAG_W-1:0] out_tag;
  logic             dz;
  logic             ovf;
  logic             busy;

  modport master (
    output in_valid, numerator, denominator, in_tag, out_ready,
    input  in_ready, out_valid, result, out_tag, dz, ovf, busy
  );

  modport slave (
    input  in_valid, numerator, denominator, in_tag, out_ready,
    output in_ready, out_valid, result, out_tag, dz, ovf, busy
  );
endinterface

// File: rtl/fx_div_seq.sv
// ---------------------------------------------------------------------------
// fx_div_seq
// Iterative signed fixed-point divider, QINT.QFRAC two's complement operands.
// Restoring division on magnitudes, BITS_PER_CYCLE quotient bits per clock,
// followed by sign application and saturation. One operation in flight.
//
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset, aborts any operation in progress
//   bus  - fx_div_seq_if.slave:
//            in_valid/in_ready/numerator/denominator/in_tag  (request)
//            out_valid/out_ready/result/out_tag/dz/ovf        (response)
//            busy                                             (state != IDLE)
//
// Optional build macro:
//   FX_DIV_ROUND_EN - round quotient magnitude half away from zero instead
//                     of truncating toward zero. Latency is unchanged.
// ---------------------------------------------------------------------------
module fx_div_seq #(
  parameter int WIDTH          = 32,
  parameter int QINT           = 16,
  parameter int QFRAC          = WIDTH - QINT,
  parameter int BITS_PER_CYCLE = 1,
  parameter int TAG_W          = 8
) (
  input  logic        clk,
  input  logic        rst,
  fx_div_seq_if.slave bus
);

  // Quotient magnitude width: the numerator is pre-scaled by 2^QFRAC.
  localparam int DW    = WIDTH + QFRAC;
  localparam int ITERS = DW / BITS_PER_CYCLE;
  localparam int CW    = $clog2(ITERS + 1);

  localparam logic [CW-1:0]    LAST_ITER = CW'(ITERS - 1);
  localparam logic [DW-1:0]    NEG_LIM   = DW'(1) << (WIDTH - 1);
  localparam logic [DW-1:0]    POS_LIM   = NEG_LIM - DW'(1);
  localparam logic [WIDTH-1:0] MAX_VAL   = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_VAL   = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    ITER,
    FIX,
    DONE
  } state_t;

  state_t state;

  // Captured request
  logic [WIDTH-1:0] num_q;
  logic [WIDTH-1:0] den_q;
  logic [TAG_W-1:0] tag_q;

  // Division datapath
  logic [DW-1:0]    dvd;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] rem;
  logic [DW-1:0]    quo;
  logic [CW-1:0]    cnt;
  logic             sign_q;
  logic             dz_q;

  // Registered outputs
  logic             in_ready_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] result_q;
  logic [TAG_W-1:0] out_tag_q;
  logic             dz_out_q;
  logic             ovf_out_q;
  logic             busy_q;

  // Next-state values of one ITER cycle and of the FIX cycle
  logic [DW-1:0]    dvd_nxt;
  logic [WIDTH-1:0] rem_nxt;
  logic [DW-1:0]    quo_nxt;
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   diff;
  logic [DW-1:0]    q_mag;
  logic [WIDTH-1:0] fix_res;
  logic             fix_ovf;
  logic [WIDTH-1:0] num_abs;
  logic [WIDTH-1:0] den_abs;

  // Magnitudes as unsigned values; |MIN| = 2^(WIDTH-1) still fits unsigned.
  assign num_abs = num_q[WIDTH-1] ? -num_q : num_q;
  assign den_abs = den_q[WIDTH-1] ? -den_q : den_q;

  // One ITER cycle of restoring division: shift the next dividend bit into
  // the partial remainder, subtract the divisor if it fits and record the
  // quotient bit, repeated BITS_PER_CYCLE times MSB first. The remainder is
  // always below the divisor, so WIDTH bits hold it and WIDTH+1 bits hold
  // the shifted trial value.
  always_comb begin
    dvd_nxt = dvd;
    rem_nxt = rem;
    quo_nxt = quo;
    trial   = '0;
    diff    = '0;
    for (int b = 0; b < BITS_PER_CYCLE; b++) begin
      trial   = {rem_nxt, dvd_nxt[DW-1]};
      diff    = trial - {1'b0, dvs};
      dvd_nxt = {dvd_nxt[DW-2:0], 1'b0};
      if (trial >= {1'b0, dvs}) begin
        rem_nxt = diff[WIDTH-1:0];
        quo_nxt = {quo_nxt[DW-2:0], 1'b1};
      end else begin
        rem_nxt = trial[WIDTH-1:0];
        quo_nxt = {quo_nxt[DW-2:0], 1'b0};
      end
    end
  end

  // FIX cycle: optional rounding of the magnitude, then sign application
  // with saturation. A negative limit one larger than the positive limit
  // lets MIN itself come out unsaturated. Negating a zero magnitude gives
  // zero, so there is no negative-zero case to handle.
  always_comb begin
    q_mag = quo;
`ifdef FX_DIV_ROUND_EN
    if ({rem, 1'b0} >= {1'b0, dvs}) begin
      q_mag = quo + DW'(1);
    end
`endif
    fix_res = '0;
    fix_ovf = 1'b0;
    if (dz_q) begin
      fix_res = num_q[WIDTH-1] ? MIN_VAL : MAX_VAL;
    end else if (!sign_q) begin
      if (q_mag > POS_LIM) begin
        fix_res = MAX_VAL;
        fix_ovf = 1'b1;
      end else begin
        fix_res = q_mag[WIDTH-1:0];
      end
    end else begin
      if (q_mag > NEG_LIM) begin
        fix_res = MIN_VAL;
        fix_ovf = 1'b1;
      end else begin
        fix_res = -q_mag[WIDTH-1:0];
      end
    end
  end

  // Control FSM and all registered state. Every state runs a fixed number
  // of cycles, so latency does not depend on operand values; a zero
  // divisor still runs the full ITER phase and its quotient is discarded.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      num_q       <= '0;
      den_q       <= '0;
      tag_q       <= '0;
      dvd         <= '0;
      dvs         <= '0;
      rem         <= '0;
      quo         <= '0;
      cnt         <= '0;
      sign_q      <= 1'b0;
      dz_q        <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      out_tag_q   <= '0;
      dz_out_q    <= 1'b0;
      ovf_out_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            num_q      <= bus.numerator;
            den_q      <= bus.denominator;
            tag_q      <= bus.in_tag;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state      <= PREP;
          end
        end
        PREP: begin
          dvd    <= DW'(num_abs) << QFRAC;
          dvs    <= den_abs;
          sign_q <= num_q[WIDTH-1] ^ den_q[WIDTH-1];
          dz_q   <= (den_q == '0);
          rem    <= '0;
          quo    <= '0;
          cnt    <= '0;
          state  <= ITER;
        end
        ITER: begin
          dvd <= dvd_nxt;
          rem <= rem_nxt;
          quo <= quo_nxt;
          cnt <= cnt + CW'(1);
          if (cnt == LAST_ITER) begin
            state <= FIX;
          end
        end
        FIX: begin
          result_q    <= fix_res;
          ovf_out_q   <= fix_ovf;
          dz_out_q    <= dz_q;
          out_tag_q   <= tag_q;
          out_valid_q <= 1'b1;
          state       <= DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            dz_out_q    <= 1'b0;
            ovf_out_q   <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.out_tag   = out_tag_q;
  assign bus.dz        = dz_out_q;
  assign bus.ovf       = ovf_out_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_fx_div_seq.sv
// ---------------------------------------------------------------------------
// tb_fx_div_seq
// Self-checking bench for fx_div_seq at default parameters (Q16.16, one
// quotient bit per cycle). Directed cases followed by random operands, all
// checked against an arithmetic reference model of the divide.
// ---------------------------------------------------------------------------
module tb_fx_div_seq;

  localparam int WIDTH   = 32;
  localparam int QFRAC   = 16;
  localparam int TAG_W   = 8;
  localparam int LATENCY = 50;
  localparam int BOUND   = 200;

  logic clk = 1'b0;
  logic rst;

  int n_asserts = 0;
  int n_fail    = 0;

  // Free-running clock
  always #5 clk = ~clk;

  fx_div_seq_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) bus_if ();

  fx_div_seq #(
    .WIDTH(WIDTH),
    .QINT(WIDTH - QFRAC),
    .QFRAC(QFRAC),
    .BITS_PER_CYCLE(1),
    .TAG_W(TAG_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
  );

  // Watchdog so the run always terminates
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference divide: scale the numerator magnitude by 2^QFRAC, integer
  // divide the magnitudes, optionally round half away from zero, apply the
  // sign and clamp to the representable range.
  function automatic void refModel(input logic [31:0] num, input logic [31:0] den,
                                   output logic [31:0] res, output logic dzf, output logic ovff);
    longint sn, sd, mag, dm, q, rm, maxp;
    bit     neg;
    sn   = longint'($signed(num));
    sd   = longint'($signed(den));
    maxp = (longint'(1) << (WIDTH - 1)) - 1;
    dzf  = 1'b0;
    ovff = 1'b0;
    if (sd == 0) begin
      dzf = 1'b1;
      res = (sn < 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
      return;
    end
    mag = ((sn < 0) ? -sn : sn) * (longint'(1) << QFRAC);
    dm  = (sd < 0) ? -sd : sd;
    q   = mag / dm;
    rm  = mag % dm;
`ifdef FX_DIV_ROUND_EN
    if (2 * rm >= dm) q = q + 1;
`else
    rm = 0;
`endif
    neg = (sn < 0) != (sd < 0);
    if (!neg && q > maxp) begin
      res  = 32'h7FFF_FFFF;
      ovff = 1'b1;
    end else if (neg && q > maxp + 1) begin
      res  = 32'h8000_0000;
      ovff = 1'b1;
    end else begin
      res = neg ? 32'(-q) : 32'(q);
    end
  endfunction

  // Wait for in_ready, then offer one operation for exactly one edge
  task automatic applyStimulus(input logic [31:0] num, input logic [31:0] den,
                               input logic [7:0] tag);
    int w = 0;
    while (bus_if.in_ready !== 1'b1 && w < BOUND) begin
      @(posedge clk); #1;
      w++;
    end
    check("accept.in_ready", 64'(bus_if.in_ready), 64'(1));
    bus_if.in_valid    = 1'b1;
    bus_if.numerator   = num;
    bus_if.denominator = den;
    bus_if.in_tag      = tag;
    @(posedge clk); #1;
    bus_if.in_valid = 1'b0;
  endtask

  // Count cycles from the accept edge to out_valid, check the response,
  // optionally stall the consumer for bp cycles, then check the return to
  // IDLE. With junk set, a second request is offered mid-operation and must
  // be ignored.
  task automatic checkOutput(input string name, input logic [31:0] exp_res,
                             input logic [7:0] exp_tag, input logic exp_dz,
                             input logic exp_ovf, input int bp, input bit junk);
    int n = 0;
    if (bp > 0) bus_if.out_ready = 1'b0;
    while (bus_if.out_valid !== 1'b1 && n < BOUND) begin
      @(posedge clk); #1;
      n++;
      if (junk && n == 10) begin
        check({name, ".busy_in_ready"}, 64'(bus_if.in_ready), 64'(0));
        bus_if.in_valid    = 1'b1;
        bus_if.numerator   = 32'h0001_0000;
        bus_if.denominator = 32'h0;
        bus_if.in_tag      = ~exp_tag;
      end else begin
        bus_if.in_valid = 1'b0;
      end
    end
    check({name, ".latency"}, 64'(n), 64'(LATENCY));
    check({name, ".result"}, 64'(bus_if.result), 64'(exp_res));
    check({name, ".out_tag"}, 64'(bus_if.out_tag), 64'(exp_tag));
    check({name, ".dz"}, 64'(bus_if.dz), 64'(exp_dz));
    check({name, ".ovf"}, 64'(bus_if.ovf), 64'(exp_ovf));
    for (int i = 0; i < bp; i++) begin
      @(posedge clk); #1;
      check($sformatf("%s.hold%0d.valid", name, i), 64'(bus_if.out_valid), 64'(1));
      check($sformatf("%s.hold%0d.result", name, i), 64'(bus_if.result), 64'(exp_res));
      check($sformatf("%s.hold%0d.flags", name, i),
            64'({bus_if.out_tag, bus_if.dz, bus_if.ovf}), 64'({exp_tag, exp_dz, exp_ovf}));
      check($sformatf("%s.hold%0d.in_ready", name, i), 64'(bus_if.in_ready), 64'(0));
    end
    bus_if.out_ready = 1'b1;
    @(posedge clk); #1;
    check({name, ".release.valid"}, 64'(bus_if.out_valid), 64'(0));
    check({name, ".release.in_ready"}, 64'(bus_if.in_ready), 64'(1));
    check({name, ".release.busy"}, 64'(bus_if.busy), 64'(0));
    check({name, ".release.flags"}, 64'({bus_if.dz, bus_if.ovf}), 64'(0));
  endtask

  // Directed sequence followed by random operations
  initial begin
    logic [31:0] num, den, er;
    logic [7:0]  tag;
    logic        ez, eo;
    logic        seen_valid;

    rst                = 1'b1;
    bus_if.in_valid    = 1'b0;
    bus_if.numerator   = '0;
    bus_if.denominator = '0;
    bus_if.in_tag      = '0;
    bus_if.out_ready   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset.in_ready", 64'(bus_if.in_ready), 64'(1));
    check("reset.out_valid", 64'(bus_if.out_valid), 64'(0));
    check("reset.result", 64'(bus_if.result), 64'(0));
    check("reset.out_tag", 64'(bus_if.out_tag), 64'(0));
    check("reset.flags", 64'({bus_if.dz, bus_if.ovf, bus_if.busy}), 64'(0));
    rst = 1'b0;

    // 3.0 / 2.0
    applyStimulus(32'h0003_0000, 32'h0002_0000, 8'h5A);
    checkOutput("div3by2", 32'h0001_8000, 8'h5A, 1'b0, 1'b0, 0, 0);

    // -7.5 / 2.5, with a stray request offered while busy
    applyStimulus(32'hFFF8_8000, 32'h0002_8000, 8'h11);
    checkOutput("neg7p5by2p5", 32'hFFFD_0000, 8'h11, 1'b0, 1'b0, 0, 1);

    // 2 / 3, truncated or rounded
    applyStimulus(32'h0002_0000, 32'h0003_0000, 8'h23);
`ifdef FX_DIV_ROUND_EN
    checkOutput("div2by3", 32'h0000_AAAB, 8'h23, 1'b0, 1'b0, 0, 0);
`else
    checkOutput("div2by3", 32'h0000_AAAA, 8'h23, 1'b0, 1'b0, 0, 0);
`endif

    // Positive overflow saturates, MIN / 1.0 does not
    applyStimulus(32'h7530_0000, 32'h0000_4000, 8'h30);
    checkOutput("ovf_pos", 32'h7FFF_FFFF, 8'h30, 1'b0, 1'b1, 0, 0);
    applyStimulus(32'h8000_0000, 32'h0001_0000, 8'h31);
    checkOutput("min_by_one", 32'h8000_0000, 8'h31, 1'b0, 1'b0, 0, 0);

    // Divide by zero, both numerator signs
    applyStimulus(32'hFFFB_0000, 32'h0, 8'h40);
    checkOutput("dz_neg", 32'h8000_0000, 8'h40, 1'b1, 1'b0, 0, 0);
    applyStimulus(32'h0005_0000, 32'h0, 8'h41);
    checkOutput("dz_pos", 32'h7FFF_FFFF, 8'h41, 1'b1, 1'b0, 0, 0);

    // Backpressure for 5 cycles, then a fresh request right after release
    applyStimulus(32'hFFFF_0000, 32'h0000_8000, 8'hB5);
    checkOutput("backpressure", 32'hFFFE_0000, 8'hB5, 1'b0, 1'b0, 5, 0);
    applyStimulus(32'h0000_0000, 32'hFFFF_0000, 8'hB6);
    checkOutput("zero_by_neg", 32'h0000_0000, 8'hB6, 1'b0, 1'b0, 0, 0);

    // Reset in ITER cycle 20 aborts the operation
    applyStimulus(32'h0007_0000, 32'h0003_0000, 8'hC0);
    repeat (20) @(posedge clk);
    #1;
    check("abort.busy_before", 64'(bus_if.busy), 64'(1));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort.in_ready", 64'(bus_if.in_ready), 64'(1));
    check("abort.out_valid", 64'(bus_if.out_valid), 64'(0));
    check("abort.busy", 64'(bus_if.busy), 64'(0));
    seen_valid = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      seen_valid = seen_valid | bus_if.out_valid;
    end
    check("abort.no_output", 64'(seen_valid), 64'(0));
    applyStimulus(32'h0001_0000, 32'h0001_0000, 8'hC1);
    checkOutput("one_by_one", 32'h0001_0000, 8'hC1, 1'b0, 1'b0, 0, 0);

    // Random operands over a wide range of magnitudes and signs
    for (int i = 0; i < 24; i++) begin
      num = 32'($urandom) >> $urandom_range(0, 20);
      if ($urandom_range(0, 1) == 1) num = -num;
      den = 32'($urandom) >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) den = -den;
      if (i % 8 == 7) den = '0;
      tag = 8'($urandom);
      refModel(num, den, er, ez, eo);
      applyStimulus(num, den, tag);
      checkOutput($sformatf("rand%0d", i), er, tag, ez, eo, (i % 5 == 0) ? 2 : 0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
